// File: rtl/sd_clk_divider_ctrl.sv
// SD card clock generator: divides clk by 2*(div_cur+1) and emits edge strobes.
// Divisor updates take effect only at falling edges, so the card never sees a runt pulse.
module sd_clk_divider_ctrl #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] divisor,
    output logic             sd_clk_o,
    output logic             rise_stb,
    output logic             fall_stb,
    output logic             upd_stb,
    output logic             busy,
    output logic [DIV_W-1:0] div_cur
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] cnt;
    logic             half_done;

    // cnt is cleared whenever div_cur can change, so it never exceeds div_cur.
    assign half_done = (cnt == div_cur);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            sd_clk_o <= 1'b0;
            rise_stb <= 1'b0;
            fall_stb <= 1'b0;
            upd_stb  <= 1'b0;
            busy     <= 1'b0;
            div_cur  <= '0;
        end else begin
            // NOTE: strobes get a default of 0 here and are overridden below; with
            // non-blocking assignments the last one in program order wins.
            rise_stb <= 1'b0;
            fall_stb <= 1'b0;
            upd_stb  <= 1'b0;

            unique case (state)
                IDLE: begin
                    cnt      <= '0;
                    sd_clk_o <= 1'b0;
                    if (en) begin
                        state   <= RUN;
                        busy    <= 1'b1;
                        div_cur <= divisor;
                        upd_stb <= (divisor != div_cur);
                    end
                end

                RUN: begin
                    if (!en && !sd_clk_o) begin
                        // Cutting a low half short is safe: low is the idle level.
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else if (half_done) begin
                        cnt      <= '0;
                        sd_clk_o <= ~sd_clk_o;
                        rise_stb <= ~sd_clk_o;
                        fall_stb <= sd_clk_o;
                        if (sd_clk_o) begin
                            div_cur <= divisor;
                            upd_stb <= (divisor != div_cur);
                            if (!en) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                        // Reaching here with en low means the clock is high.
                        if (!en) state <= STOP;
                    end
                end

                STOP: begin
                    if (half_done) begin
                        cnt      <= '0;
                        sd_clk_o <= 1'b0;
                        fall_stb <= 1'b1;
                        state    <= IDLE;
                        busy     <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_clk_divider_ctrl.sv
// Bench for sd_clk_divider_ctrl: directed scenarios plus random stimulus,
// compared each cycle against a countdown-style model of the card clock.
module tb_sd_clk_divider_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [7:0] divisor = '0;
    logic       sd_clk_o, rise_stb, fall_stb, upd_stb, busy;
    logic [7:0] div_cur;

    int vectors = 0;
    int miscompares = 0;

    sd_clk_divider_ctrl #(.DIV_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .divisor  (divisor),
        .sd_clk_o (sd_clk_o),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb),
        .upd_stb  (upd_stb),
        .busy     (busy),
        .div_cur  (div_cur)
    );

    always #5 clk = ~clk;

    // Reference model: tracks whether the clock is being generated, its level,
    // and how many cycles remain in the current half.
    bit       m_on = 0, m_stop = 0, m_lvl = 0, m_rise = 0, m_fall = 0, m_upd = 0;
    int       m_left = 0;
    bit [7:0] m_div = '0;

    function automatic logic [12:0] dut_vec();
        return {sd_clk_o, rise_stb, fall_stb, upd_stb, busy, div_cur};
    endfunction

    function automatic logic [12:0] mdl_vec();
        return {m_lvl, m_rise, m_fall, m_upd, m_on, m_div};
    endfunction

    task automatic tick();
        bit       r = rst;
        bit       e = en;
        bit [7:0] d = divisor;
        bit       was_stop;
        @(posedge clk);
        m_rise = 0; m_fall = 0; m_upd = 0;
        if (r) begin
            m_on = 0; m_stop = 0; m_lvl = 0; m_div = '0;
        end else if (!m_on) begin
            if (e) begin
                m_on = 1; m_stop = 0; m_lvl = 0;
                m_upd = (d != m_div);
                m_div = d;
                m_left = int'(m_div) + 1;
            end
        end else if (!m_stop && !e && !m_lvl) begin
            m_on = 0;
        end else begin
            was_stop = m_stop;
            m_left--;
            if (m_left == 0) begin
                m_lvl  = !m_lvl;
                m_rise = m_lvl;
                m_fall = !m_lvl;
                if (!m_lvl) begin
                    if (!was_stop) begin
                        m_upd = (d != m_div);
                        m_div = d;
                    end
                    if (was_stop || !e) begin
                        m_on = 0; m_stop = 0;
                    end
                end
                m_left = int'(m_div) + 1;
            end else if (!e) begin
                m_stop = 1;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; divisor = 8'd5;
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if (dut_vec() !== 13'h0) begin
                miscompares++;
                $display("FAIL reset_hold: got %h want %h", dut_vec(), 13'h0);
            end
        end
        rst = 1'b0;
        tick();
        vectors++;
        if (dut_vec() !== {5'b00011, 8'd5} || dut_vec() !== mdl_vec()) begin
            miscompares++;
            $display("FAIL reset_run_entry: got %h want %h", dut_vec(), {5'b00011, 8'd5});
        end
        do_reset();
    endtask

    task automatic test_div3();
        int rises[$];
        int falls[$];
        int upd_n = 0;
        divisor = 8'd3; en = 1'b1;
        tick();
        vectors++;
        if (upd_stb !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL div3_entry: upd=%b busy=%b want 1 1", upd_stb, busy);
        end
        for (int c = 1; c <= 40; c++) begin
            tick();
            vectors++;
            if (dut_vec() !== mdl_vec()) begin
                miscompares++;
                $display("FAIL div3_model c=%0d: got %h want %h", c, dut_vec(), mdl_vec());
            end
            if (rise_stb) rises.push_back(c);
            if (fall_stb) falls.push_back(c);
            if (upd_stb) upd_n++;
        end
        vectors++;
        if (rises.size() != 5 || falls.size() != 5 || upd_n != 0) begin
            miscompares++;
            $display("FAIL div3_counts: rises=%0d falls=%0d upd=%0d want 5 5 0",
                     rises.size(), falls.size(), upd_n);
        end else begin
            for (int i = 0; i < 5; i++) begin
                vectors++;
                if (rises[i] != 4 + 8 * i || falls[i] != 8 + 8 * i) begin
                    miscompares++;
                    $display("FAIL div3_edges i=%0d: rise@%0d fall@%0d want %0d %0d",
                             i, rises[i], falls[i], 4 + 8 * i, 8 + 8 * i);
                end
            end
        end
        vectors++;
        if (div_cur !== 8'd3) begin
            miscompares++;
            $display("FAIL div3_div_cur: got %0d want 3", div_cur);
        end
        do_reset();
    endtask

    task automatic test_div0();
        divisor = 8'd0; en = 1'b1;
        tick();
        for (int c = 1; c <= 16; c++) begin
            tick();
            vectors++;
            if ({sd_clk_o, rise_stb, fall_stb} !== {c[0], c[0], ~c[0]} || dut_vec() !== mdl_vec()) begin
                miscompares++;
                $display("FAIL div0_toggle c=%0d: clk/rise/fall=%b%b%b want %b%b%b",
                         c, sd_clk_o, rise_stb, fall_stb, c[0], c[0], ~c[0]);
            end
        end
        do_reset();
    endtask

    task automatic test_div_change();
        int n = 0;
        int high = 1;
        divisor = 8'd3; en = 1'b1;
        tick();
        do begin
            tick(); n++;
        end while (!rise_stb && n < 20);
        vectors++;
        if (!rise_stb) begin
            miscompares++;
            $display("FAIL chg_wait_rise: no rise_stb within %0d cycles", n);
        end
        tick();
        if (sd_clk_o) high++;
        divisor = 8'd1;
        n = 0;
        do begin
            tick(); n++;
            vectors++;
            if (dut_vec() !== mdl_vec()) begin
                miscompares++;
                $display("FAIL chg_model: got %h want %h", dut_vec(), mdl_vec());
            end
            if (sd_clk_o) high++;
        end while (!fall_stb && n < 20);
        vectors++;
        if (high != 4 || upd_stb !== 1'b1 || div_cur !== 8'd1) begin
            miscompares++;
            $display("FAIL chg_boundary: high=%0d upd=%b div_cur=%0d want 4 1 1",
                     high, upd_stb, div_cur);
        end
        tick(); tick();
        vectors++;
        if (rise_stb !== 1'b1) begin
            miscompares++;
            $display("FAIL chg_new_low: rise_stb=%b want 1 two cycles after fall", rise_stb);
        end
        tick(); tick();
        vectors++;
        if (fall_stb !== 1'b1 || upd_stb !== 1'b0) begin
            miscompares++;
            $display("FAIL chg_new_high: fall=%b upd=%b want 1 0", fall_stb, upd_stb);
        end
        do_reset();
    endtask

    task automatic test_stop();
        int n = 0;
        int high = 1;
        divisor = 8'd3; en = 1'b1;
        tick();
        do begin
            tick(); n++;
        end while (!rise_stb && n < 20);
        en = 1'b0;
        n = 0;
        do begin
            tick(); n++;
            if (sd_clk_o) high++;
            if (n == 2) en = 1'b1;   // re-request while stopping must be ignored
        end while (!fall_stb && n < 20);
        vectors++;
        if (high != 4 || busy !== 1'b0 || dut_vec() !== mdl_vec()) begin
            miscompares++;
            $display("FAIL stop_high_half: high=%0d busy=%b want 4 0", high, busy);
        end
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if ({sd_clk_o, rise_stb, fall_stb, busy} !== 4'b0000) begin
                miscompares++;
                $display("FAIL stop_idle: clk/rise/fall/busy=%b want 0000",
                         {sd_clk_o, rise_stb, fall_stb, busy});
            end
        end
        en = 1'b1;
        tick(); tick(); tick();
        en = 1'b0;
        tick();
        vectors++;
        if ({sd_clk_o, rise_stb, fall_stb, busy} !== 4'b0000 || dut_vec() !== mdl_vec()) begin
            miscompares++;
            $display("FAIL stop_low_half: clk/rise/fall/busy=%b want 0000",
                     {sd_clk_o, rise_stb, fall_stb, busy});
        end
        do_reset();
    endtask

    task automatic test_en_bounce();
        int n = 0;
        divisor = 8'd2; en = 1'b1;
        tick(); tick();
        en = 1'b0;
        tick();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL bounce_idle: busy=%b want 0", busy);
        end
        en = 1'b1;
        tick();
        do begin
            tick(); n++;
        end while (!rise_stb && n < 20);
        vectors++;
        if (n != 3 || dut_vec() !== mdl_vec()) begin
            miscompares++;
            $display("FAIL bounce_low_len: rise after %0d cycles want 3", n);
        end
        do_reset();
    endtask

    task automatic test_rst_mid();
        int n = 0;
        divisor = 8'd3; en = 1'b1;
        tick();
        do begin
            tick(); n++;
        end while (!rise_stb && n < 20);
        tick();
        rst = 1'b1;
        tick();
        vectors++;
        if (dut_vec() !== 13'h0) begin
            miscompares++;
            $display("FAIL rst_mid_high: got %h want %h", dut_vec(), 13'h0);
        end
        rst = 1'b0; en = 1'b0;
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 15) == 0) en = ~en;
            if ($urandom_range(0, 9) == 0)
                divisor = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 40))
                                                       : 8'($urandom_range(0, 5));
            rst = ($urandom_range(0, 299) == 0);
            tick();
            vectors++;
            if (dut_vec() !== mdl_vec() || (rise_stb && fall_stb)) begin
                miscompares++;
                $display("FAIL random c=%0d: got %h want %h", c, dut_vec(), mdl_vec());
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_div3();
        test_div0();
        test_div_change();
        test_stop();
        test_en_bounce();
        test_rst_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
